// File: rtl/pt_walk_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// pt_pkg
//   Shared definitions for the page-table walk arbiter: PTE field geometry,
//   field positions inside an 8-bit {VPN,PPN} entry, and the walker state
//   encoding used by pt_walk_arbiter.
// ---------------------------------------------------------------------------
package pt_pkg;

  localparam int VPN_W = 4;
  localparam int PPN_W = 4;
  localparam int PTE_W = VPN_W + PPN_W;

  // Field positions inside one page-table entry: {VPN, PPN}
  localparam int PTE_VPN_MSB = PTE_W - 1;
  localparam int PTE_VPN_LSB = PPN_W;
  localparam int PTE_PPN_MSB = PPN_W - 1;
  localparam int PTE_PPN_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } pt_state_e;

endpackage

// File: rtl/pt_walk_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker. Grants the first set request at
//   or after ptr, wrapping around to index 0.
// Ports
//   req        in   NREQ  request vector
//   ptr        in   IW    highest-priority index for this decision
//   grant      out  NREQ  one-hot grant (zero when no request)
//   grant_idx  out  IW    binary index of the granted requester
//   any_req    out  1     at least one request is pending
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any_req
);

  logic          hit_hi_s;
  logic          hit_lo_s;
  logic [IW-1:0] idx_hi_s;
  logic [IW-1:0] idx_lo_s;

  // Two scans: lowest request at/after ptr, else lowest request overall (wrap)
  always_comb begin
    hit_hi_s = 1'b0;
    hit_lo_s = 1'b0;
    idx_hi_s = '0;
    idx_lo_s = '0;
    // Descending scan so the lowest qualifying index is the one left behind
    for (int i = NREQ - 1; i >= 0; i--) begin
      hit_hi_s = (req[i] && (i >= int'(ptr))) ? 1'b1   : hit_hi_s;
      idx_hi_s = (req[i] && (i >= int'(ptr))) ? IW'(i) : idx_hi_s;
      hit_lo_s = req[i] ? 1'b1   : hit_lo_s;
      idx_lo_s = req[i] ? IW'(i) : idx_lo_s;
    end
    if (hit_hi_s) begin
      grant_idx = idx_hi_s;
    end else begin
      grant_idx = idx_lo_s;
    end
    any_req = hit_lo_s;
    if (hit_lo_s) begin
      grant = NREQ'(1) << grant_idx;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/pt_walk_arbiter.sv
// ---------------------------------------------------------------------------
// pt_walk_arbiter
//   Shares one speculative page table between NREQ TLB-miss requesters.
//   Round-robin arbitration, one lookup in flight, and a timeout that aborts
//   lookups for unmapped VPNs (the table never completes those) and returns
//   a fault instead. All outputs are registered.
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   req           per-requester level miss request, held until its done
//   req_addr      per-requester VPN, slice i = [4i+3:4i]
//   done          one-hot, 1-cycle result pulse for the owning requester
//   fault         with done: 1 = timed out, rsp_data is 0
//   rsp_data      with done: {VPN,PPN} entry from the table
//   pt_rqst       lookup request to the page table
//   pt_addr       VPN presented to the page table (held for the lookup)
//   pt_abort      1-cycle pulse returning the table to idle after a timeout
//   pt_complete   table lookup complete (combinational from the table)
//   pt_return     table entry, only meaningful while pt_complete=1
// ---------------------------------------------------------------------------
module pt_walk_arbiter
  import pt_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [VPN_W*NREQ-1:0] req_addr,
  output logic [NREQ-1:0]       done,
  output logic                  fault,
  output logic [PTE_W-1:0]      rsp_data,
  output logic                  pt_rqst,
  output logic [VPN_W-1:0]      pt_addr,
  output logic                  pt_abort,
  input  logic                  pt_complete,
  input  logic [PTE_W-1:0]      pt_return
);

  localparam int            IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  pt_state_e        state_r,    state_s;
  logic [IW-1:0]    owner_r,    owner_s;
  logic [NREQ-1:0]  owner_oh_r, owner_oh_s;
  logic [IW-1:0]    rr_ptr_r,   rr_ptr_s;
  logic [TW-1:0]    tmo_r,      tmo_s;
  logic [NREQ-1:0]  done_r,     done_s;
  logic             fault_r,    fault_s;
  logic [PTE_W-1:0] rsp_data_r, rsp_data_s;
  logic             pt_rqst_r,  pt_rqst_s;
  logic [VPN_W-1:0] pt_addr_r,  pt_addr_s;
  logic             pt_abort_r, pt_abort_s;

  logic [NREQ-1:0]  grant_s;
  logic [IW-1:0]    grant_idx_s;
  logic             any_req_s;
  logic [VPN_W-1:0] addr_sel_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req       (req),
    .ptr       (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any_req   (any_req_s)
  );

  // VPN of the requester the arbiter is currently picking
  always_comb begin
    addr_sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      addr_sel_s = (grant_idx_s == IW'(i)) ? req_addr[VPN_W*i +: VPN_W] : addr_sel_s;
    end
  end

  // Next-state and next-output logic for the walk sequencer
  always_comb begin
    state_s    = state_r;
    owner_s    = owner_r;
    owner_oh_s = owner_oh_r;
    rr_ptr_s   = rr_ptr_r;
    tmo_s      = tmo_r;
    pt_rqst_s  = pt_rqst_r;
    pt_addr_s  = pt_addr_r;
    // Pulse outputs fall back to zero unless this edge enters RESP
    done_s     = '0;
    fault_s    = 1'b0;
    rsp_data_s = '0;
    pt_abort_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          owner_s    = grant_idx_s;
          owner_oh_s = grant_s;
          pt_addr_s  = addr_sel_s;
          pt_rqst_s  = 1'b1;
          tmo_s      = '0;
          state_s    = WAIT;
        end else begin
          pt_rqst_s  = 1'b0;
        end
      end

      WAIT: begin
        // Completion is checked first so it wins over an expiry on the same edge;
        // pt_return is only looked at while the table flags it valid.
        if (pt_complete) begin
          rsp_data_s = pt_return;
          done_s     = owner_oh_r;
          pt_rqst_s  = 1'b0;
          state_s    = RESP;
        end else if (tmo_r == TMO_LAST) begin
          fault_s    = 1'b1;
          done_s     = owner_oh_r;
          pt_rqst_s  = 1'b0;
          pt_abort_s = 1'b1;
          state_s    = RESP;
        end else begin
          tmo_s      = tmo_r + TW'(1);
        end
      end

      RESP: begin
        // The owner drops to lowest priority for the next decision
        if (owner_r == IW'(NREQ - 1)) begin
          rr_ptr_s = '0;
        end else begin
          rr_ptr_s = owner_r + IW'(1);
        end
        state_s = IDLE;
      end

      default: begin
        pt_rqst_s = 1'b0;
        state_s   = IDLE;
      end
    endcase
  end

  // State, bookkeeping and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      owner_r    <= '0;
      owner_oh_r <= '0;
      rr_ptr_r   <= '0;
      tmo_r      <= '0;
      done_r     <= '0;
      fault_r    <= 1'b0;
      rsp_data_r <= '0;
      pt_rqst_r  <= 1'b0;
      pt_addr_r  <= '0;
      pt_abort_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      owner_r    <= owner_s;
      owner_oh_r <= owner_oh_s;
      rr_ptr_r   <= rr_ptr_s;
      tmo_r      <= tmo_s;
      done_r     <= done_s;
      fault_r    <= fault_s;
      rsp_data_r <= rsp_data_s;
      pt_rqst_r  <= pt_rqst_s;
      pt_addr_r  <= pt_addr_s;
      pt_abort_r <= pt_abort_s;
    end
  end

  assign done     = done_r;
  assign fault    = fault_r;
  assign rsp_data = rsp_data_r;
  assign pt_rqst  = pt_rqst_r;
  assign pt_addr  = pt_addr_r;
  assign pt_abort = pt_abort_r;

endmodule

// File: tb/tb_pt_walk_arbiter.sv
module tb_pt_walk_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [7:0] req_addr = 8'h00;
  logic [1:0] done;
  logic       fault;
  logic [7:0] rsp_data;
  logic       pt_rqst;
  logic [3:0] pt_addr;
  logic       pt_abort;
  logic       pt_complete;
  logic [7:0] pt_return;

  always #5 clk = ~clk;

  pt_walk_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
    .done(done), .fault(fault), .rsp_data(rsp_data),
    .pt_rqst(pt_rqst), .pt_addr(pt_addr), .pt_abort(pt_abort),
    .pt_complete(pt_complete), .pt_return(pt_return)
  );

  // ---------------- page table: scans one entry per cycle -----------------
  logic [7:0] tbl [8];
  bit         override_hit = 1'b0;   // forces a hit exactly on the last WAIT cycle
  int         pt_idx;

  initial tbl = '{8'h15, 8'h5B, 8'h3A, 8'h9C, 8'h21, 8'h64, 8'h77, 8'hE2};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pt_idx <= 0;
    else if (!pt_rqst || pt_complete) pt_idx <= 0;
    else pt_idx <= pt_idx + 1;
  end

  always_comb begin
    pt_complete = 1'b0;
    if (pt_rqst) begin
      if (override_hit) pt_complete = (pt_idx == TIMEOUT - 1);
      else if (pt_idx < 8) pt_complete = (tbl[pt_idx][7:4] == pt_addr);
    end
  end

  assign pt_return = !pt_complete ? 8'hzz : (override_hit ? 8'hF5 : tbl[pt_idx]);

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: rr choice, first table hit index k, done k+1 cycles after issue
  bit         m_busy = 1'b0;
  int         m_owner, m_rr = 0, m_n0, m_k, m_d;
  bit         m_fault;
  logic [7:0] m_data;
  logic [3:0] m_addr = 4'h0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 1'b0; m_rr = 0; m_addr = 4'h0;
      end else begin
        cyc++;
        if (m_busy && cyc == m_d + 1) begin
          m_busy = 1'b0;
        end else if (!m_busy && req != 2'b00) begin
          m_owner = -1;
          for (int j = 0; j < NREQ; j++) begin
            int c;
            c = (m_rr + j) % NREQ;
            if (m_owner < 0 && req[c]) m_owner = c;
          end
          m_addr = req_addr[4*m_owner +: 4];
          if (override_hit) begin
            m_k = TIMEOUT - 1; m_fault = 1'b0; m_data = 8'hF5;
          end else begin
            m_k = -1;
            for (int t = 0; t < 8; t++)
              if (m_k < 0 && tbl[t][7:4] == m_addr) begin m_k = t; m_data = tbl[t]; end
            if (m_k < 0 || m_k > TIMEOUT - 1) begin m_k = TIMEOUT - 1; m_fault = 1'b1; m_data = 8'h00; end
            else m_fault = 1'b0;
          end
          m_n0 = cyc; m_d = cyc + m_k + 1; m_busy = 1'b1; m_rr = (m_owner + 1) % NREQ;
        end
      end
      #1;
      check("pt_rqst", pt_rqst, (m_busy && cyc <= m_n0 + m_k));
      check("pt_addr", pt_addr, m_addr);
      check("done", done, (m_busy && cyc == m_d) ? (2'b01 << m_owner) : 2'b00);
      check("pt_abort", pt_abort, (m_busy && cyc == m_d && m_fault));
      if (m_busy && cyc == m_d) begin
        check("fault", fault, m_fault);
        check("rsp_data", rsp_data, m_data);
      end
    end
  end

  // ---------------- requesters and event logs ----------------
  logic [3:0] vq0[$], vq1[$];
  int         done_owner[$], done_cyc[$], rise_cyc[$];
  logic [7:0] done_data[$];
  bit         done_fault[$], done_abort[$], done_rqst[$];
  logic [3:0] rise_addr[$];
  bit         prev_rqst = 1'b0;

  task automatic tick();
    @(negedge clk);
    if (pt_rqst && !prev_rqst) begin rise_cyc.push_back(cyc); rise_addr.push_back(pt_addr); end
    prev_rqst = pt_rqst;
    if (done != 2'b00) begin
      done_owner.push_back(done[1] ? 1 : 0);
      done_data.push_back(rsp_data);
      done_fault.push_back(fault);
      done_abort.push_back(pt_abort);
      done_rqst.push_back(pt_rqst);
      done_cyc.push_back(cyc);
      if (done[0] && vq0.size() != 0) void'(vq0.pop_front());
      if (done[1] && vq1.size() != 0) void'(vq1.pop_front());
    end
    req[0] = (vq0.size() != 0);
    req[1] = (vq1.size() != 0);
    req_addr[3:0] = (vq0.size() != 0) ? vq0[0] : 4'h0;
    req_addr[7:4] = (vq1.size() != 0) ? vq1[0] : 4'h0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((vq0.size() != 0 || vq1.size() != 0) && n < budget) begin tick(); n++; end
    check("drain_budget", vq0.size() + vq1.size(), 0);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 2'b00; req_addr = 8'h00; vq0.delete(); vq1.delete();
    @(negedge clk);
    rst_n = 1'b1; prev_rqst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int b, r, cnt;

  initial begin
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // 1. single hit: VPN 3 found at table index 2
    b = done_owner.size(); r = rise_cyc.size();
    vq0.push_back(4'h3);
    drain(100);
    check("t1_count", done_owner.size() - b, 1);
    check("t1_owner", done_owner[b], 0);
    check("t1_data", done_data[b], 8'h3A);
    check("t1_fault", done_fault[b], 1'b0);
    check("t1_rqst_low_at_done", done_rqst[b], 1'b0);
    check("t1_addr", rise_addr[r], 4'h3);
    check("t1_latency", done_cyc[b] - rise_cyc[r], 3);

    // 2. simultaneous requests from reset
    do_reset();
    b = done_owner.size(); r = rise_cyc.size();
    vq0.push_back(4'h1); vq1.push_back(4'h5);
    drain(100);
    check("t2_count", done_owner.size() - b, 2);
    check("t2_first", done_owner[b], 0);
    check("t2_second", done_owner[b+1], 1);
    check("t2_data0", done_data[b], 8'h15);
    check("t2_data1", done_data[b+1], 8'h5B);
    check("t2_spacing", rise_cyc[r+1] - rise_cyc[r], 3);
    b = done_owner.size();
    vq0.push_back(4'h3); vq1.push_back(4'h9);
    drain(100);
    check("t2_ptr_back_to_0", done_owner[b], 0);
    check("t2_data_again", done_data[b+1], 8'h9C);

    // 3. unmapped VPN times out, next request still works
    b = done_owner.size(); r = rise_cyc.size();
    vq0.push_back(4'hF);
    drain(200);
    check("t3_fault", done_fault[b], 1'b1);
    check("t3_data", done_data[b], 8'h00);
    check("t3_abort", done_abort[b], 1'b1);
    check("t3_wait_cycles", done_cyc[b] - rise_cyc[r], TIMEOUT);
    vq1.push_back(4'h3);
    drain(100);
    check("t3_next_owner", done_owner[b+1], 1);
    check("t3_next_data", done_data[b+1], 8'h3A);
    check("t3_next_fault", done_fault[b+1], 1'b0);

    // 4. fairness with requester 0 held high continuously
    do_reset();
    b = done_owner.size();
    vq0.push_back(4'h1); vq0.push_back(4'h3); vq0.push_back(4'h1); vq0.push_back(4'h3);
    tick();
    vq1.push_back(4'h5); vq1.push_back(4'h9);
    drain(400);
    check("t4_count", done_owner.size() - b, 6);
    check("t4_g0", done_owner[b],   0);
    check("t4_g1", done_owner[b+1], 1);
    check("t4_g2", done_owner[b+2], 0);
    check("t4_g3", done_owner[b+3], 1);

    // 5. reset in the middle of a lookup
    vq0.push_back(4'hF);
    repeat (6) tick();
    cnt = done_owner.size();
    @(negedge clk);
    rst_n = 1'b0; req = 2'b00; req_addr = 8'h00; vq0.delete(); vq1.delete();
    #1;
    check("t5_async_rqst", pt_rqst, 1'b0);
    check("t5_async_done", done, 2'b00);
    @(negedge clk);
    rst_n = 1'b1; prev_rqst = 1'b0;
    repeat (4) tick();
    check("t5_no_done", done_owner.size() - cnt, 0);
    vq1.push_back(4'h9);
    drain(100);
    check("t5_clean_owner", done_owner[cnt], 1);
    check("t5_clean_data", done_data[cnt], 8'h9C);

    // 6. completion on the expiry edge wins over the timeout
    override_hit = 1'b1;
    b = done_owner.size(); r = rise_cyc.size();
    vq0.push_back(4'hF);
    drain(200);
    override_hit = 1'b0;
    check("t6_fault", done_fault[b], 1'b0);
    check("t6_data", done_data[b], 8'hF5);
    check("t6_abort", done_abort[b], 1'b0);
    check("t6_cycles", done_cyc[b] - rise_cyc[r], TIMEOUT);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
